// File: rtl/cpu_pkg.sv
// Shared Avalon-MM command/response types and arbiter state encoding for the
// dual-core UART access path.
package cpu_pkg;

  localparam int AVL_AW = 4;
  localparam int AVL_DW = 32;

  // Avalon-MM command from a master (chipselect doubles as the request).
  typedef struct packed {
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [AVL_AW-1:0] address;
    logic [AVL_DW-1:0] writedata;
  } AvlC;

  // Avalon-MM response back to a master.
  typedef struct packed {
    logic [AVL_DW-1:0] readdata;
    logic              waitrequest;
  } AvlR;

  typedef enum logic [1:0] {arb_IDLE, arb_XFER, arb_ABORT} ArbSt;

  // Quiescent command presented to the slave whenever no transfer is live.
  localparam AvlC AVLC_IDLE = '{chipselect: 1'b0, read_n: 1'b1, write_n: 1'b1,
                                address: '0, writedata: '0};

  // Request vector {m1, m0} taken from the two masters' chipselects.
  function automatic logic [1:0] avl_req(input AvlC c0, input AvlC c1);
    return {c1.chipselect, c0.chipselect};
  endfunction

endpackage

// File: rtl/uart_arb_rr2.sv
// Two-way request picker: a lone requester always wins; on a tie the
// winner is m0 in fixed-priority mode, otherwise the one rr_ptr points at.
module uart_arb_rr2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       fixed,
  output logic [1:0] gnt
);

  // One-hot grant decode of the current request pair.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (fixed || !rr_ptr) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_avl_arb.sv
// Shares one Avalon-MM UART slave between two core bridges. One master owns
// the slave per transfer; a watchdog aborts transfers stalled too long so a
// hung slave cycle cannot lock both cores.
module uart_avl_arb
  import cpu_pkg::*;
#(
  parameter int TIMEOUT    = 1024,
  parameter int PRIO_FIXED = 0,
  parameter int TO_W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  AvlC  m0_avlc,
  output AvlR  m0_avlr,
  input  AvlC  m1_avlc,
  output AvlR  m1_avlr,
  output AvlC  s_avlc,
  input  AvlR  s_avlr,
  output logic err_o,
  output logic err_id_o,
  input  logic err_clr_i
);

  ArbSt            state;
  logic            owner;
  logic            rr_ptr;
  logic [TO_W-1:0] wdog;
  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            xfer;
  logic            done;
  logic            abort;
  AvlC             own_cmd;

  assign req = avl_req(m0_avlc, m1_avlc);

  uart_arb_rr2 u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .fixed  (PRIO_FIXED != 0),
    .gnt    (gnt)
  );

  assign xfer    = (state == arb_XFER);
  assign done    = xfer & ~s_avlr.waitrequest;
  assign abort   = xfer & s_avlr.waitrequest & (wdog == TO_W'(TIMEOUT - 1));
  // Slave command depends only on registered state and the owner's command,
  // never on the slave's own waitrequest.
  assign own_cmd = owner ? m1_avlc : m0_avlc;
  assign s_avlc  = xfer ? own_cmd : AVLC_IDLE;

  // Route the slave response: readdata is broadcast, only the owner is released.
  always_comb begin
    m0_avlr.readdata    = s_avlr.readdata;
    m0_avlr.waitrequest = 1'b1;
    m1_avlr.readdata    = s_avlr.readdata;
    m1_avlr.waitrequest = 1'b1;
    if ((done || abort) && !owner) begin
      m0_avlr.waitrequest = 1'b0;
      if (abort) m0_avlr.readdata = '0;
    end
    if ((done || abort) && owner) begin
      m1_avlr.waitrequest = 1'b0;
      if (abort) m1_avlr.readdata = '0;
    end
  end

  // Arbitration FSM with stall watchdog and sticky abort flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= arb_IDLE;
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
      wdog     <= '0;
      err_o    <= 1'b0;
      err_id_o <= 1'b0;
    end else begin
      case (state)
        arb_IDLE: begin
          if (|req) begin
            owner  <= gnt[1];
            rr_ptr <= ~gnt[1];
            wdog   <= '0;
            state  <= arb_XFER;
          end
        end
        arb_XFER: begin
          if (done) begin
            wdog  <= '0;
            state <= arb_IDLE;
          end else if (abort) begin
            wdog     <= '0;
            err_id_o <= owner;
            state    <= arb_ABORT;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        arb_ABORT: state <= arb_IDLE;
        default:   state <= arb_IDLE;
      endcase
      // A fresh abort outranks a clear arriving in the same cycle.
      if (abort)          err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_avl_arb.sv
// Bench for uart_avl_arb: a round-robin and a fixed-priority instance share
// one stimulus stream and are each compared every cycle against a
// transfer-level reference model.
module tb_uart_avl_arb;
  import cpu_pkg::*;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  AvlC  m0c, m1c;
  AvlR  sr;
  logic eclr;

  AvlC  s_c0, s_c1;
  AvlR  m0r0, m1r0, m0r1, m1r1;
  logic err0, eid0, err1, eid1;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model: per instance, the transfer in flight (if any)
  bit busy[2], abrt[2], own[2], pref[2], merr[2], meid[2];
  int stall[2];

  // Observations recorded at each check point
  logic        obs_cs[2], obs_m0wr[2], obs_m1wr[2], obs_err[2], obs_eid[2];
  logic [3:0]  obs_addr[2];
  logic [31:0] obs_m1rd[2];
  int          ack_m0[2], ack_m1[2];

  always #5 clk = ~clk;

  uart_avl_arb #(.TIMEOUT(TMO), .PRIO_FIXED(0)) u_rr (
    .clk(clk), .rst(rst), .m0_avlc(m0c), .m0_avlr(m0r0), .m1_avlc(m1c), .m1_avlr(m1r0),
    .s_avlc(s_c0), .s_avlr(sr), .err_o(err0), .err_id_o(eid0), .err_clr_i(eclr));

  uart_avl_arb #(.TIMEOUT(TMO), .PRIO_FIXED(1)) u_fx (
    .clk(clk), .rst(rst), .m0_avlc(m0c), .m0_avlr(m0r1), .m1_avlc(m1c), .m1_avlr(m1r1),
    .s_avlc(s_c1), .s_avlr(sr), .err_o(err1), .err_id_o(eid1), .err_clr_i(eclr));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic AvlC mk(input logic cs, input logic wr, input logic [3:0] a,
                             input logic [31:0] d);
    AvlC c;
    c.chipselect = cs;
    c.read_n     = wr;
    c.write_n    = !wr;
    c.address    = a;
    c.writedata  = d;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; abrt[i] = 0; own[i] = 0; pref[i] = 0;
      merr[i] = 0; meid[i] = 0; stall[i] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      AvlC  sc, ec;
      AvlR  r0, r1;
      logic e, ei;
      bit   xf, dn, ab;
      sc = (i == 1) ? s_c1 : s_c0;
      r0 = (i == 1) ? m0r1 : m0r0;
      r1 = (i == 1) ? m1r1 : m1r0;
      e  = (i == 1) ? err1 : err0;
      ei = (i == 1) ? eid1 : eid0;
      xf = busy[i] && !abrt[i];
      dn = xf && !sr.waitrequest;
      ab = xf && sr.waitrequest && (stall[i] == TMO - 1);
      ec = AVLC_IDLE;
      if (xf) ec = own[i] ? m1c : m0c;
      check($sformatf("s_avlc[%0d]", i), 64'(sc), 64'(ec));
      check($sformatf("m0_wait[%0d]", i), 64'(r0.waitrequest), 64'(!((dn || ab) && !own[i])));
      check($sformatf("m1_wait[%0d]", i), 64'(r1.waitrequest), 64'(!((dn || ab) && own[i])));
      check($sformatf("m0_rdata[%0d]", i), 64'(r0.readdata),
            (ab && !own[i]) ? 64'd0 : 64'(sr.readdata));
      check($sformatf("m1_rdata[%0d]", i), 64'(r1.readdata),
            (ab && own[i]) ? 64'd0 : 64'(sr.readdata));
      check($sformatf("err[%0d]", i), 64'(e), 64'(merr[i]));
      check($sformatf("err_id[%0d]", i), 64'(ei), 64'(meid[i]));
      obs_cs[i]   = sc.chipselect;
      obs_addr[i] = sc.address;
      obs_m0wr[i] = r0.waitrequest;
      obs_m1wr[i] = r1.waitrequest;
      obs_m1rd[i] = r1.readdata;
      obs_err[i]  = e;
      obs_eid[i]  = ei;
      if (!r0.waitrequest) ack_m0[i]++;
      if (!r1.waitrequest) ack_m1[i]++;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit xf, dn, ab, w;
      if (rst) begin
        busy[i] = 0; abrt[i] = 0; own[i] = 0; pref[i] = 0;
        merr[i] = 0; meid[i] = 0; stall[i] = 0;
      end else begin
        xf = busy[i] && !abrt[i];
        dn = xf && !sr.waitrequest;
        ab = xf && sr.waitrequest && (stall[i] == TMO - 1);
        if (abrt[i]) begin
          abrt[i] = 0; busy[i] = 0;
        end else if (xf) begin
          if (dn) begin
            busy[i] = 0; stall[i] = 0;
          end else if (ab) begin
            abrt[i] = 1; merr[i] = 1; meid[i] = own[i]; stall[i] = 0;
          end else begin
            stall[i]++;
          end
        end else if (m0c.chipselect || m1c.chipselect) begin
          if (m0c.chipselect && m1c.chipselect) w = (i == 1) ? 1'b0 : pref[i];
          else w = m1c.chipselect;
          own[i] = w; pref[i] = !w; busy[i] = 1; stall[i] = 0;
        end
        if (!ab && eclr) merr[i] = 0;
      end
    end
  endtask

  // One clock: check outputs, advance the model on the edge, return at negedge.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL tb_timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    bit got;
    int q[$];
    int a0, a1;

    rst = 1'b1; eclr = 1'b0;
    m0c = AVLC_IDLE; m1c = AVLC_IDLE;
    sr.waitrequest = 1'b1; sr.readdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin ack_m0[i] = 0; ack_m1[i] = 0; end
    model_reset();
    @(negedge clk);
    cycle(); cycle();
    check("rst_cs", 64'(s_c0.chipselect), 64'd0);
    check("rst_rw", 64'({s_c0.read_n, s_c0.write_n}), 64'd3);
    check("rst_m0wait", 64'(m0r0.waitrequest), 64'd1);
    check("rst_m1wait", 64'(m1r0.waitrequest), 64'd1);
    check("rst_err", 64'(err0), 64'd0);
    rst = 1'b0;

    // Single write with a two-cycle slave stall
    m0c = mk(1'b1, 1'b1, 4'd0, 32'h41);
    sr.waitrequest = 1'b1;
    cycle();
    check("t1_cs_c0", 64'(obs_cs[0]), 64'd0);
    cycle();
    check("t1_cs_c1", 64'(obs_cs[0]), 64'd1);
    check("t1_wait_c1", 64'(obs_m0wr[0]), 64'd1);
    cycle();
    sr.waitrequest = 1'b0;
    cycle();
    check("t1_ack_c3", 64'(obs_m0wr[0]), 64'd0);
    m0c = AVLC_IDLE;
    cycle();
    check("t1_idle_c4", 64'(obs_cs[0]), 64'd0);

    // Tie after reset: m0, then m1, then m0 again
    apply_reset();
    sr.waitrequest = 1'b0;
    m0c = mk(1'b1, 1'b0, 4'd1, 32'h0);
    m1c = mk(1'b1, 1'b0, 4'd2, 32'h0);
    cycle();
    cycle();
    check("t2_first_m0", 64'(obs_addr[0]), 64'd1);
    m0c = AVLC_IDLE;
    cycle();
    cycle();
    check("t2_then_m1", 64'(obs_addr[0]), 64'd2);
    m1c = AVLC_IDLE;
    cycle();
    m0c = mk(1'b1, 1'b0, 4'd1, 32'h0);
    m1c = mk(1'b1, 1'b0, 4'd2, 32'h0);
    cycle();
    cycle();
    check("t2_tie_m0", 64'(obs_addr[0]), 64'd1);
    m0c = AVLC_IDLE; m1c = AVLC_IDLE;
    cycle(); cycle();

    // Both masters requesting continuously, zero-wait slave
    a0 = ack_m0[1]; a1 = ack_m1[1];
    m0c = mk(1'b1, 1'b0, 4'd1, 32'h0);
    m1c = mk(1'b1, 1'b0, 4'd2, 32'h0);
    for (int k = 0; k < 24; k++) begin
      sr.readdata = $urandom;
      cycle();
      if (!obs_m0wr[0]) q.push_back(0);
      if (!obs_m1wr[0]) q.push_back(1);
    end
    check("t3_acks", 64'(q.size()), 64'd12);
    for (int k = 1; k < q.size(); k++) check("t3_alternate", 64'(q[k]), 64'(1 - q[k-1]));
    check("t6_fixed_m1", 64'(ack_m1[1] - a1), 64'd0);
    check("t6_fixed_m0", 64'(ack_m0[1] - a0), 64'd12);
    m0c = AVLC_IDLE; m1c = AVLC_IDLE;
    cycle(); cycle();

    // Stuck slave: watchdog releases m1 with zero readdata
    m1c = mk(1'b1, 1'b0, 4'd3, 32'h0);
    sr.waitrequest = 1'b1;
    sr.readdata = 32'hDEAD_BEEF;
    n = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      if (obs_cs[0]) n++;
      if (!obs_m1wr[0]) got = 1;
    end
    check("t4_released", 64'(got), 64'd1);
    check("t4_xfer_len", 64'(n), 64'd8);
    check("t4_rdata", 64'(obs_m1rd[0]), 64'd0);
    m1c = AVLC_IDLE;
    cycle();
    check("t4_err", 64'(obs_err[0]), 64'd1);
    check("t4_err_id", 64'(obs_eid[0]), 64'd1);
    eclr = 1'b1;
    cycle();
    eclr = 1'b0;
    cycle();
    check("t4_err_clr", 64'(obs_err[0]), 64'd0);

    // Asynchronous reset in the middle of a transfer
    m0c = mk(1'b1, 1'b1, 4'd1, 32'h55);
    sr.waitrequest = 1'b1;
    cycle();
    cycle();
    check("t5_in_xfer", 64'(obs_cs[0]), 64'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("t5_cs_drop", 64'(s_c0.chipselect), 64'd0);
    check("t5_m0_wait", 64'(m0r0.waitrequest), 64'd1);
    check("t5_m1_wait", 64'(m1r0.waitrequest), 64'd1);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    sr.waitrequest = 1'b0;
    m1c = mk(1'b1, 1'b0, 4'd2, 32'h0);
    cycle();
    cycle();
    check("t5_m0_pref", 64'(obs_addr[0]), 64'd1);
    m0c = AVLC_IDLE; m1c = AVLC_IDLE;
    cycle();

    // Randomized traffic with occasional long stalls and error clears
    n = 0;
    for (int k = 0; k < 1500; k++) begin
      m0c = mk(($urandom % 4) != 0, 1'($urandom), 4'($urandom), $urandom);
      m1c = mk(($urandom % 4) != 0, 1'($urandom), 4'($urandom), $urandom);
      if (n > 0) begin
        sr.waitrequest = 1'b1;
        n--;
      end else if (($urandom % 40) == 0) begin
        sr.waitrequest = 1'b1;
        n = 10;
      end else begin
        sr.waitrequest = (($urandom % 3) == 0);
      end
      sr.readdata = $urandom;
      eclr = (($urandom % 16) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
